// File: rtl/fc_mac_sequencer.sv
// ============================================================================
// Module  : fc_mac_sequencer
// Brief   : One FC neuron: streams (activation, weight) pairs, Q5.11 multiply
//           with saturating requantize, saturating accumulate onto a bias.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_mac_sequencer #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 11,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sat_flag,
  output logic              busy
);

  localparam logic [DATA_W-1:0] c_max = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] c_min = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [LEN_W-1:0]    r_cnt;
  logic [LEN_W-1:0]    r_len;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_s1_q;
  logic                r_s1_vld;
  logic                r_sat;
  logic                r_out_valid;
  logic                r_busy;

  logic                w_accept;
  logic signed [2*DATA_W-1:0] w_p;
  logic signed [2*DATA_W-1:0] w_sh;
  logic                w_q_ovf;
  logic [DATA_W-1:0]   w_q;
  logic [DATA_W:0]     w_s;
  logic                w_s_ovf;
  logic [DATA_W-1:0]   w_acc_next;

  assign in_ready  = (r_state == ST_RUN) && (r_cnt != r_len);
  assign w_accept  = in_valid & in_ready;

  // Truncating shift keeps floor semantics; the value fits the output format
  // only when every bit from the output sign upward is a sign copy.
  assign w_p     = $signed(in_data) * $signed(in_weight);
  assign w_sh    = w_p >>> FRAC_W;
  assign w_q_ovf = !((&w_sh[2*DATA_W-1:DATA_W-1]) || (~|w_sh[2*DATA_W-1:DATA_W-1]));
  assign w_q     = w_q_ovf ? (w_sh[2*DATA_W-1] ? c_min : c_max) : w_sh[DATA_W-1:0];

  assign w_s        = {r_acc[DATA_W-1], r_acc} + {r_s1_q[DATA_W-1], r_s1_q};
  assign w_s_ovf    = w_s[DATA_W] != w_s[DATA_W-1];
  assign w_acc_next = w_s_ovf ? (w_s[DATA_W] ? c_min : c_max) : w_s[DATA_W-1:0];

  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign sat_flag  = r_sat;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_acc       <= '0;
      r_s1_q      <= '0;
      r_s1_vld    <= 1'b0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_q <= w_q;
        r_cnt  <= r_cnt + LEN_W'(1);
      end
      // Stage 2 also fires on the RUN->OUT edge to absorb the last product.
      if (r_s1_vld) begin
        r_acc <= w_acc_next;
      end
      r_sat <= r_sat | (w_accept & w_q_ovf) | (r_s1_vld & w_s_ovf);

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len   <= length;
            r_acc   <= bias;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_cnt == r_len) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/fc_mac_sequencer.md
Name: fc_mac_sequencer

Overview:
- Sequences one fully-connected neuron: streams N (activation, weight) pairs, multiplies each in Q5.11, requantizes each product to Q5.11 with saturation, and accumulates onto a bias with saturating Q5.11 addition.
- Sits between the FC input/weight buffers and the FC output writer, one instance per output lane.
- Delivers one saturated 16-bit result per job, plus a sticky saturation flag.

Parameters:
- DATA_W, 16, operand/result width; fixed Q5.11 format (5 integer bits including sign, 11 fraction bits).
- FRAC_W, 11, fraction bits.
- LEN_W, 10, width of the job length field; maximum length is 2^LEN_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- length  in  LEN_W  number of pairs in the job; captured on start.
- bias  in  16  Q5.11 initial accumulator value; captured on start.
- in_valid  in  1  pair available.
- in_ready  out  1  sequencer accepts a pair.
- in_data  in  16  Q5.11 activation.
- in_weight  in  16  Q5.11 weight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  Q5.11 result.
- sat_flag  out  1  a saturation occurred during the current job; meaningful while out_valid=1.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset, asynchronous on rst_n=0: state returns to IDLE; count, accumulator, captured length, stage-1 register, stage-1 valid bit and sat_flag all clear to 0.
  - Outputs in reset: in_ready=0, out_valid=0, out_data=0, busy=0.
  - Reset mid-job discards the job with no output.
- State IDLE:
  - start=1 captures length and bias; acc<=bias, cnt<=0, sat_flag<=0; next state RUN.
  - start is ignored in every other state.
- State RUN:
  - in_ready = (cnt != len_q), driven combinationally.
  - A pair is accepted when in_valid & in_ready. On acceptance: cnt<=cnt+1, and stage 1 registers the requantized product with its valid bit set.
  - Gaps in in_valid simply stall the job.
  - When cnt==len_q, the next state is OUT.
- Stage 1, product requantize:
  - p = signed in_data * signed in_weight, 32 bits.
  - ip = p[31:22], signed.
  - If ip>15, q=16'h7FFF. If ip<-16, q=16'h8000. Otherwise q={p[26:22], p[21:11]} (truncation, no rounding).
  - Any clamp sets sat_flag.
- Stage 2, accumulate:
  - Runs in every cycle the stage-1 valid bit is set, including the RUN->OUT transition edge.
  - s = sign-extended acc + sign-extended q, 17 bits. is = s[16:11].
  - If is>15, acc=16'h7FFF. If is<-16, acc=16'h8000. Otherwise acc=s[15:0].
  - Any clamp sets sat_flag.
  - Saturation is applied per step, so the accumulation order is fixed as arrival order.
- Latency:
  - out_valid rises exactly 2 cycles after the cycle in which the last pair is accepted.
  - For length=0, out_valid rises 2 cycles after the start cycle and out_data=bias.
- State OUT:
  - out_valid=1, out_data=acc; out_data and sat_flag are held stable until out_ready=1.
  - On out_valid & out_ready, the next state is IDLE. A new start is accepted no earlier than the following cycle.
- busy=1 in RUN and OUT. in_ready=0 in IDLE and OUT.

Test Plan:
- Basic job: length=3, bias=0x0800; pairs (0x0800,0x1000), (0x0400,0x0400), (0xF800,0x0800), one per cycle, out_ready=1 -> out_data=0x1200 (2.25), sat_flag=0, out_valid 2 cycles after the third accept, in_ready low after the third accept.
- Product saturation: length=1, bias=0; pair (0x4000,0x2000), i.e. 8.0*4.0 -> out_data=0x7FFF, sat_flag=1. A follow-up job with pair (0x0800,0x0800) -> 0x0800, sat_flag=0 (flag clears on start).
- Accumulation saturation: bias=0x8000; pair (0xF800,0x0800) -> out_data=0x8000, sat_flag=1. Also bias=0x7800 with pair (0x1000,0x0800) -> 0x7FFF, sat_flag=1.
- length=0, bias=0x1234 -> in_ready never asserts; out_valid 2 cycles after start; out_data=0x1234.
- Backpressure: in_valid toggles 1/0 over a length=4 job; out_ready held 0 for 5 cycles; start pulsed while busy -> result identical to the gap-free run; out_data stable while waiting; the extra start is ignored.
- Reset mid-job: rst_n=0 asserted after 2 of 4 accepts -> all outputs 0 immediately, state IDLE. A new start then completes correctly with no residue from the aborted job.
